bus_region_decoder: RTL and testbench
=====================================

Name: bus_region_decoder

Overview:
- Registered, parametrised successor to the fixed SRAM/flash decoder on the 6809 bus.
- Holds NUM_REGIONS programmable base/mask windows with lowest-index priority.
- Generates one-hot chip selects and a per-region wait-state count.
- Drives a bus-ready handshake so slow devices (SPI flash bridge) can stretch the CPU cycle; flags accesses that hit no region.

Parameters:
ADDR_W, 16, CPU address width
NUM_REGIONS, 4, number of decode windows (2..8)
WS_W, 4, wait-state counter width (max 2^WS_W-1 wait cycles)
R0_BASE, 16'h0000, reset base of region 0 (SRAM)
R0_MASK, 16'hF000, reset mask of region 0
R0_WS, 0, reset wait states of region 0
R1_BASE, 16'hF000, reset base of region 1 (SPI flash)
R1_MASK, 16'hF000, reset mask of region 1
R1_WS, 8, reset wait states of region 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
bus_valid  in  1  CPU access request, held high for the whole access
address  in  ADDR_W  CPU address, stable while bus_valid high
cfg_we  in  1  config write strobe
cfg_idx  in  3  region index to write
cfg_base  in  ADDR_W  new base
cfg_mask  in  ADDR_W  new mask
cfg_ws  in  WS_W  new wait-state count
cfg_en  in  1  new region enable
cs  out  NUM_REGIONS  one-hot chip selects, active high
bus_ready  out  1  access may complete
busy  out  1  access in progress (not IDLE)
unmapped  out  1  current access hit no enabled region

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - Outputs: cs=0, bus_ready=0, busy=0, unmapped=0; state IDLE; ws counter 0.
  - Region 0 = {R0_BASE, R0_MASK, R0_WS, en=1}; region 1 = {R1_BASE, R1_MASK, R1_WS, en=1}.
  - Regions 2..NUM_REGIONS-1 = {0, 0, 0, en=0}.
- Match rule: region i hits when en_i and (address & mask_i) == (base_i & mask_i). A mask of 0 matches every address. Lowest hitting index wins, so cs is always one-hot or zero.
- States:
  - IDLE: on bus_valid=1 (cycle N), latch the winning index and its ws, go to WAIT or HOLD.
  - WAIT: ws counter decrements each cycle; at 0 go to HOLD.
  - HOLD: bus_ready=1; stay until bus_valid=0 is sampled, then go to IDLE.
- Timing:
  - cs and busy assert at N+1.
  - ws=0: bus_ready also asserts at N+1 (state goes directly to HOLD).
  - ws=k: bus_ready asserts at N+1+k.
  - cs, busy and bus_ready deassert in the cycle after bus_valid=0 is sampled.
- Unmapped access: cs stays 0; unmapped=1 and bus_ready=1 at N+1 with zero wait states; both held until bus_valid drops.
- Back-to-back accesses: a new access starts only from IDLE, so bus_valid must be low for at least one sampled cycle between accesses.
- bus_valid dropping during WAIT: abort; next cycle cs=0, busy=0, IDLE, and bus_ready never pulses.
- Config writes:
  - cfg_we writes region cfg_idx on the clock edge.
  - cfg_idx >= NUM_REGIONS is ignored.
  - Writes are accepted in any state. An in-flight access keeps its latched index and ws; new values apply from the next IDLE decode.
  - A write in the same cycle an access is latched does not affect that access.
- Address handling: address is only sampled in IDLE; later changes are ignored.
- Reset mid-access: all outputs drop immediately (asynchronously) and config returns to the parameter defaults.

Test Plan:
- After reset, bus_valid=1 with address=16'h0123 → at N+1 cs=4'b0001, bus_ready=1, unmapped=0; drop bus_valid → next cycle cs=0, busy=0.
- address=16'hF800 → cs=4'b0010 at N+1, bus_ready first high at N+9 (8 wait states), held until bus_valid drops.
- address=16'h8000 with defaults → cs=0, unmapped=1, bus_ready=1 at N+1.
- Program region 2 {base=16'h8000, mask=16'hC000, ws=2, en=1}, then address=16'h8ABC → cs=4'b0100, ready at N+3. Program region 0 mask=0 → any address now gives cs=4'b0001 (priority).
- Flash access with bus_valid dropped at N+4 → no bus_ready pulse, IDLE at N+5; a cfg_we to region 1 issued mid-WAIT does not alter that access's ready time.
- rst_n low during WAIT → cs, bus_ready, busy 0 immediately; after release, region 2 is disabled and region 1 is back to ws=8.

Source files
------------

// File: rtl/bus_region_decoder.sv
// rtl/bus_region_decoder.sv - registered base/mask bus region decoder with wait-state ready handshake
module bus_region_decoder #(
  parameter int                ADDR_W      = 16,
  parameter int                NUM_REGIONS = 4,
  parameter int                WS_W        = 4,
  parameter logic [ADDR_W-1:0] R0_BASE     = 16'h0000,
  parameter logic [ADDR_W-1:0] R0_MASK     = 16'hF000,
  parameter int                R0_WS       = 0,
  parameter logic [ADDR_W-1:0] R1_BASE     = 16'hF000,
  parameter logic [ADDR_W-1:0] R1_MASK     = 16'hF000,
  parameter int                R1_WS       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bus_valid,
  input  logic [ADDR_W-1:0]      address,
  input  logic                   cfg_we,
  input  logic [2:0]             cfg_idx,
  input  logic [ADDR_W-1:0]      cfg_base,
  input  logic [ADDR_W-1:0]      cfg_mask,
  input  logic [WS_W-1:0]        cfg_ws,
  input  logic                   cfg_en,
  output logic [NUM_REGIONS-1:0] cs,
  output logic                   bus_ready,
  output logic                   busy,
  output logic                   unmapped
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  logic [ADDR_W-1:0] r_base [NUM_REGIONS];
  logic [ADDR_W-1:0] r_mask [NUM_REGIONS];
  logic [WS_W-1:0]   r_ws   [NUM_REGIONS];
  logic              r_en   [NUM_REGIONS];

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic              r_mapped;
  logic [WS_W-1:0]   r_ws_cnt;

  state_t            w_state_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic              w_mapped_nxt;
  logic [WS_W-1:0]   w_cnt_nxt;

  logic              w_hit;
  logic [IDX_W-1:0]  w_hit_idx;
  logic [WS_W-1:0]   w_hit_ws;

  // Region table: parameter defaults on reset, out-of-range indices never match a slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (i == 0) begin
          r_base[i] <= R0_BASE;
          r_mask[i] <= R0_MASK;
          r_ws[i]   <= WS_W'(R0_WS);
          r_en[i]   <= 1'b1;
        end else if (i == 1) begin
          r_base[i] <= R1_BASE;
          r_mask[i] <= R1_MASK;
          r_ws[i]   <= WS_W'(R1_WS);
          r_en[i]   <= 1'b1;
        end else begin
          r_base[i] <= '0;
          r_mask[i] <= '0;
          r_ws[i]   <= '0;
          r_en[i]   <= 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (cfg_we && (cfg_idx == 3'(i))) begin
          r_base[i] <= cfg_base;
          r_mask[i] <= cfg_mask;
          r_ws[i]   <= cfg_ws;
          r_en[i]   <= cfg_en;
        end
      end
    end
  end

  // Priority match: scan high to low so the lowest hitting index is left standing
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_hit_ws  = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (r_en[i] && ((address & r_mask[i]) == (r_base[i] & r_mask[i]))) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
        w_hit_ws  = r_ws[i];
      end
    end
  end

  // Access state, latched winner and wait-state counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_mapped <= 1'b0;
      r_ws_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_mapped <= w_mapped_nxt;
      r_ws_cnt <= w_cnt_nxt;
    end
  end

  // Next state: counter holds ws-1 on entry to WAIT so HOLD lands exactly ws cycles later
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_mapped_nxt = r_mapped;
    w_cnt_nxt    = r_ws_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus_valid) begin
          w_idx_nxt    = w_hit_idx;
          w_mapped_nxt = w_hit;
          if (!w_hit || (w_hit_ws == '0)) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = w_hit_ws - WS_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (!bus_valid) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_ws_cnt == '0) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_nxt = r_ws_cnt - WS_W'(1);
        end
      end
      S_HOLD: begin
        if (!bus_valid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // One-hot chip select from the latched winner while an access is live
  always_comb begin
    cs = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      cs[i] = (r_state != S_IDLE) && r_mapped && (r_idx == IDX_W'(i));
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign bus_ready = (r_state == S_HOLD);
  assign unmapped  = (r_state != S_IDLE) && !r_mapped;

endmodule

// File: tb/tb_bus_region_decoder.sv
// tb/tb_bus_region_decoder.sv - directed self-checking bench for bus_region_decoder
module tb_bus_region_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_valid;
  logic [15:0] address;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [15:0] cfg_base;
  logic [15:0] cfg_mask;
  logic [3:0]  cfg_ws;
  logic        cfg_en;
  logic [3:0]  cs;
  logic        bus_ready;
  logic        busy;
  logic        unmapped;

  int n_vec = 0;
  int n_bad = 0;

  bus_region_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_valid (bus_valid),
    .address   (address),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_base  (cfg_base),
    .cfg_mask  (cfg_mask),
    .cfg_ws    (cfg_ws),
    .cfg_en    (cfg_en),
    .cs        (cs),
    .bus_ready (bus_ready),
    .busy      (busy),
    .unmapped  (unmapped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After return we sit 1ns past the edge that sampled bus_valid=1 (cycle N+1)
  task automatic start(input logic [15:0] a);
    address   = a;
    bus_valid = 1'b1;
    tick();
  endtask

  task automatic drop(input string tag);
    bus_valid = 1'b0;
    tick();
    chk({tag, "_cs0"}, cs, 4'b0000);
    chk({tag, "_busy0"}, busy, 1'b0);
    chk({tag, "_rdy0"}, bus_ready, 1'b0);
    chk({tag, "_unm0"}, unmapped, 1'b0);
  endtask

  task automatic run_to_ready(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    while (!bus_ready && lat < 40) begin
      tick();
      lat++;
    end
    chk(tag, lat, exp_lat);
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [15:0] b, input logic [15:0] m,
                     input logic [3:0] w, input logic e);
    cfg_idx  = idx;
    cfg_base = b;
    cfg_mask = m;
    cfg_ws   = w;
    cfg_en   = e;
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; bus_valid = 1'b0; address = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_mask = '0; cfg_ws = '0; cfg_en = 1'b0;
    tick(); tick();
    chk("rst_cs", cs, 4'b0000);
    chk("rst_rdy", bus_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_unm", unmapped, 1'b0);
    rst_n = 1'b1;
    tick();

    // SRAM, zero wait states
    start(16'h0123);
    chk("sram_cs", cs, 4'b0001);
    chk("sram_rdy", bus_ready, 1'b1);
    chk("sram_unm", unmapped, 1'b0);
    chk("sram_busy", busy, 1'b1);
    drop("sram");

    // Flash, 8 wait states, address change during HOLD ignored
    start(16'hF800);
    chk("fl_cs", cs, 4'b0010);
    chk("fl_rdy_n1", bus_ready, 1'b0);
    run_to_ready("fl_lat", 9);
    address = 16'h0000;
    tick(); tick();
    chk("fl_hold_rdy", bus_ready, 1'b1);
    chk("fl_hold_cs", cs, 4'b0010);
    drop("fl");

    // Unmapped
    start(16'h8000);
    chk("um_cs", cs, 4'b0000);
    chk("um_unm", unmapped, 1'b1);
    chk("um_rdy", bus_ready, 1'b1);
    tick();
    chk("um_hold", unmapped, 1'b1);
    drop("um");

    // Region 2 programmed with 2 wait states
    cfg(3'd2, 16'h8000, 16'hC000, 4'd2, 1'b1);
    tick();
    start(16'h8ABC);
    chk("r2_cs", cs, 4'b0100);
    run_to_ready("r2_lat", 3);
    drop("r2");

    // Out-of-range index write must be ignored
    cfg(3'd5, 16'h0000, 16'h0000, 4'd0, 1'b1);
    tick();
    start(16'h4000);
    chk("oor_unm", unmapped, 1'b1);
    chk("oor_cs", cs, 4'b0000);
    drop("oor");

    // Region 0 mask=0 matches everything and wins on priority
    cfg(3'd0, 16'h0000, 16'h0000, 4'd0, 1'b1);
    tick();
    start(16'hF800);
    chk("pri_cs", cs, 4'b0001);
    chk("pri_rdy", bus_ready, 1'b1);
    drop("pri");
    cfg(3'd0, 16'h0000, 16'hF000, 4'd0, 1'b1);
    tick();

    // Abort during WAIT: bus_valid sampled low at end of N+4
    start(16'hF800);
    for (int j = 0; j < 3; j++) begin
      chk("ab_rdy_wait", bus_ready, 1'b0);
      tick();
    end
    chk("ab_rdy_n4", bus_ready, 1'b0);
    chk("ab_busy_n4", busy, 1'b1);
    bus_valid = 1'b0;
    tick();
    chk("ab_busy", busy, 1'b0);
    chk("ab_cs", cs, 4'b0000);
    chk("ab_rdy", bus_ready, 1'b0);
    tick();
    chk("ab_rdy_after", bus_ready, 1'b0);

    // Write to region 1 mid-WAIT leaves the in-flight access at 9 cycles
    start(16'hF800);
    cfg_idx = 3'd1; cfg_base = 16'hF000; cfg_mask = 16'hF000; cfg_ws = 4'd1; cfg_en = 1'b1;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    lat = 2;
    while (!bus_ready && lat < 40) begin
      tick();
      lat++;
    end
    chk("midw_lat", lat, 9);
    drop("midw");

    // Write latched in the same cycle as the access: old ws=1 applies now, ws=3 next time
    cfg_idx = 3'd1; cfg_base = 16'hF000; cfg_mask = 16'hF000; cfg_ws = 4'd3; cfg_en = 1'b1;
    cfg_we = 1'b1;
    start(16'hF123);
    cfg_we = 1'b0;
    run_to_ready("same_lat", 2);
    drop("same");
    start(16'hF123);
    run_to_ready("new_lat", 4);
    drop("new");

    // Asynchronous reset mid-WAIT restores defaults
    cfg(3'd1, 16'hF000, 16'hF000, 4'd5, 1'b1);
    tick();
    start(16'hF800);
    tick();
    chk("rw_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rw_cs", cs, 4'b0000);
    chk("rw_rdy", bus_ready, 1'b0);
    chk("rw_busy", busy, 1'b0);
    bus_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start(16'h8ABC);
    chk("rw_r2_unm", unmapped, 1'b1);
    chk("rw_r2_cs", cs, 4'b0000);
    drop("rw_r2");
    start(16'hF800);
    chk("rw_r1_cs", cs, 4'b0010);
    run_to_ready("rw_r1_lat", 9);
    drop("rw_r1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
